// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART Tx line between NREQ byte requesters.
// Frame: start(0), data LSB first, even parity (^data), two stop bits; CLK_DIV clocks per bit.
module uart_tx_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned GID_W   = 2,
  parameter int unsigned CLK_DIV = 1085
) (
  input  logic                CLOCK_125_p,
  input  logic                RESET,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [GID_W-1:0]    grant_id,
  output logic                busy,
  output logic                frame_done,
  output logic                Tx
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [10:0] DIV_LAST = 11'(CLK_DIV - 1);

  state_t           state;
  state_t           next_state;
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] pick;
  logic             any_req;
  logic [7:0]       pick_byte;
  logic [10:0]      div_cnt;
  logic [3:0]       bit_idx;
  logic [10:0]      frame;      // remaining bits after the start bit: {stop, stop, parity, data}
  logic             accept;
  logic             bit_end;
  logic             last_bit;

  assign bit_end  = (div_cnt == DIV_LAST);
  assign last_bit = (bit_idx == 4'd11);

  // Pick the first valid requester scanning upward from rr_ptr, wrapping to 0
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_valid[i] && (i >= 32'(rr_ptr))) begin
        pick    = GID_W'(i);
        any_req = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_valid[i] && (i < 32'(rr_ptr))) begin
        pick    = GID_W'(i);
        any_req = 1'b1;
      end
    end
  end

  // Select the granted requester's byte
  always_comb begin
    pick_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(pick) == i) pick_byte = req_data[8*i +: 8];
    end
  end

  // Next-state logic plus the combinational accept and frame_done strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req_ready  = '0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        // RESET gate keeps req_ready low while reset is held (state already reads IDLE)
        if (any_req && !RESET) begin
          accept     = 1'b1;
          req_ready  = NREQ'(1) << pick;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end && last_bit) begin
          frame_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLOCK_125_p or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Datapath: latch on accept, then shift one frame bit out every CLK_DIV clocks
  always_ff @(posedge CLOCK_125_p or posedge RESET) begin
    if (RESET) begin
      Tx       <= 1'b1;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      frame    <= '1;
    end else if (accept) begin
      frame    <= {2'b11, ^pick_byte, pick_byte};
      Tx       <= 1'b0;
      busy     <= 1'b1;
      div_cnt  <= '0;
      bit_idx  <= '0;
      grant_id <= pick;
      rr_ptr   <= (pick == GID_W'(NREQ - 1)) ? '0 : pick + GID_W'(1);
    end else if (state == SHIFT) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (last_bit) begin
          Tx      <= 1'b1;
          busy    <= 1'b0;
          bit_idx <= '0;
        end else begin
          Tx      <= frame[0];
          frame   <= {1'b1, frame[10:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        div_cnt <= div_cnt + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of single-frame vectors plus multi-cycle sequences.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: NREQ=4, CLK_DIV=4
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy, frame_done, tx;

  // Second DUT: CLK_DIV=1
  logic        rst_b;
  logic [3:0]  req_valid_b;
  logic [31:0] req_data_b;
  logic [3:0]  req_ready_b;
  logic [1:0]  grant_id_b;
  logic        busy_b, frame_done_b, tx_b;

  uart_tx_scheduler #(.NREQ(4), .GID_W(2), .CLK_DIV(4)) dut (
    .CLOCK_125_p(clk), .RESET(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .Tx(tx)
  );

  uart_tx_scheduler #(.NREQ(4), .GID_W(2), .CLK_DIV(1)) dut_b (
    .CLOCK_125_p(clk), .RESET(rst_b), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .grant_id(grant_id_b), .busy(busy_b), .frame_done(frame_done_b), .Tx(tx_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [1:0]  grant;
    logic [11:0] frame;   // bit k = Tx level during bit k (bit 0 = start)
  } vec_t;

  vec_t vecs [8];

  // Called in the phase posedge+1; returns at posedge+2 of the accept cycle
  task automatic wait_accept(output logic [3:0] got);
    int unsigned n;
    n = 0;
    #1;
    while (req_ready == 4'd0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
    got = req_ready;
  endtask

  // Called at posedge+1 of the first cycle after accept; returns at posedge+1 of the first idle cycle
  task automatic watch_frame(input logic [1:0] g, input logic [11:0] f);
    logic [11:0] sh;
    check("grant_id", grant_id, g);
    check("busy_in_frame", busy, 1);
    sh = f;
    for (int unsigned k = 0; k < 48; k++) begin
      check("tx_bit", tx, sh[0]);
      check("frame_done", frame_done, (k == 47));
      check("ready_in_shift", req_ready, 0);
      if (k % 4 == 3) sh = sh >> 1;
      @(posedge clk); #1;
    end
    check("tx_idle_after", tx, 1);
    check("busy_idle_after", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] got;
    req_valid = v.mask;
    req_data  = v.data;
    wait_accept(got);
    check("req_ready", got, 32'd1 << v.grant);
    check("busy_at_accept", busy, 0);
    @(posedge clk); #1;
    req_valid = '0;
    req_data  = '0;
    watch_frame(v.grant, v.frame);
  endtask

  logic [11:0] b2b_frames [4];

  initial begin
    logic [3:0]  got;
    int unsigned early;
    logic        seen;

    vecs[0] = '{mask: 4'b0100, data: 32'h00A50000, grant: 2'd2, frame: 12'hD4A};
    vecs[1] = '{mask: 4'b1111, data: 32'h3CA5FF01, grant: 2'd3, frame: 12'hC78};
    vecs[2] = '{mask: 4'b1111, data: 32'h3CA5FF01, grant: 2'd0, frame: 12'hE02};
    vecs[3] = '{mask: 4'b1111, data: 32'h3CA5FF01, grant: 2'd1, frame: 12'hDFE};
    vecs[4] = '{mask: 4'b1010, data: 32'h80005A00, grant: 2'd3, frame: 12'hF00};
    vecs[5] = '{mask: 4'b1010, data: 32'h80005A00, grant: 2'd1, frame: 12'hCB4};
    vecs[6] = '{mask: 4'b0001, data: 32'h00000000, grant: 2'd0, frame: 12'hC00};
    vecs[7] = '{mask: 4'b1000, data: 32'h7E000000, grant: 2'd3, frame: 12'hCFC};

    b2b_frames[0] = 12'hE26;  // 0x13
    b2b_frames[1] = 12'hC44;  // 0x22
    b2b_frames[2] = 12'hC66;  // 0x33
    b2b_frames[3] = 12'hC88;  // 0x44

    rst = 1'b1; req_valid = '0; req_data = '0;
    rst_b = 1'b1; req_valid_b = '0; req_data_b = '0;

    // Reset values, including req_ready held low with valids present
    #12;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_grant_id", grant_id, 0);
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: single frames, round-robin pointer, skipping idle requesters
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back with all valids held: grants 0,1,2,3 with a single idle cycle between frames
    req_valid = 4'hF;
    req_data  = 32'h44332213;
    wait_accept(got);
    for (int unsigned j = 0; j < 4; j++) begin
      if (j > 0) begin
        #1;
        got = req_ready;
      end
      check("b2b_ready", got, 32'd1 << j);
      @(posedge clk); #1;
      watch_frame(2'(j), b2b_frames[j]);
      if (j == 3) req_valid = '0;
    end

    // Busy hold: a request raised mid-frame waits until the cycle after frame_done
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    wait_accept(got);
    check("hold_first_ready", got, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    req_data  = 32'h0000005A;
    #1;
    early = 0;
    seen  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (seen) break;
      if (req_ready != 4'd0) early++;
      if (frame_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("hold_frame_done_seen", seen, 1);
    check("hold_early_ready", early, 0);
    check("hold_ready_after_done", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    watch_frame(2'd0, 12'hCB4);

    // Reset mid-frame: Tx high at once, busy low, pointer back to 0
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    wait_accept(got);
    check("abort_ready", got, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check("abort_tx_start", tx, 0);
    check("abort_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_frame_done", frame_done, 0);
    check("abort_grant_id", grant_id, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_resend_tx", tx, 1);
    req_valid = 4'hF;
    req_data  = 32'h000000A5;
    wait_accept(got);
    check("abort_next_grant", got, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    watch_frame(2'd0, 12'hD4A);

    // CLK_DIV=1: byte 0x00 from req 0, one cycle per bit
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk); #1;
    req_valid_b = 4'b0001;
    req_data_b  = 32'h0;
    #1;
    check("div1_ready", req_ready_b, 4'b0001);
    @(posedge clk); #1;
    req_valid_b = '0;
    check("div1_busy", busy_b, 1);
    for (int unsigned k = 0; k < 12; k++) begin
      check("div1_tx", tx_b, (k >= 10) || (k == 11));
      check("div1_frame_done", frame_done_b, (k == 11));
      @(posedge clk); #1;
    end
    check("div1_tx_idle", tx_b, 1);
    check("div1_busy_idle", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
